// File: rtl/mmio_timer_pwm.sv
// mmio_timer_pwm: memory-mapped PWM channels, free-running ms/us counters
// and a millisecond compare timer with one-shot or periodic interrupt.
module mmio_timer_pwm #(
  parameter int unsigned CLK_FREQ_HZ = 12000000,
  parameter int unsigned NUM_PWM     = 4,
  parameter int unsigned PWM_DIV     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFFFFE0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               write_mem,
  input  logic [2:0]         funct3,
  input  logic [31:0]        write_address,
  input  logic [31:0]        write_data,
  input  logic [31:0]        read_address,
  output logic [31:0]        read_data,
  output logic               read_hit,
  output logic [NUM_PWM-1:0] pwm_out,
  output logic               irq
);

  localparam int unsigned US_DIV = CLK_FREQ_HZ / 1000000;
  localparam int unsigned MS_DIV = CLK_FREQ_HZ / 1000;

  localparam logic [2:0] REG_DUTY_LO = 3'd0;
  localparam logic [2:0] REG_DUTY_HI = 3'd1;
  localparam logic [2:0] REG_MILLIS  = 3'd2;
  localparam logic [2:0] REG_MICROS  = 3'd3;
  localparam logic [2:0] REG_CMP     = 3'd4;
  localparam logic [2:0] REG_CTRL    = 3'd5;
  localparam logic [2:0] REG_STATUS  = 3'd6;
  localparam logic [2:0] REG_PERIOD  = 3'd7;

  // Shadow duties written by software and the copies the comparators use
  logic [7:0]  duty        [NUM_PWM];
  logic [7:0]  active_duty [NUM_PWM];
  logic [7:0]  active_next [NUM_PWM];
  logic [63:0] duty_all;

  logic [31:0] us_pre, ms_pre, micros, millis, millis_next;
  logic [31:0] cmp, period;
  logic [1:0]  ctrl;
  logic        pending;
  logic        us_tick, ms_tick, match;

  logic [31:0] div_cnt;
  logic [7:0]  pwm_cnt, cnt_next;
  logic        pwm_step, period_load;
  logic [NUM_PWM-1:0] pwm_next;

  logic        wr_hit;
  logic [2:0]  wr_sel;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rd_in_window;
  logic [31:0] rd_value;
  logic        unused_bits;

  assign unused_bits = ^{funct3[2], read_address[1:0]};

  assign wr_hit = write_mem && (write_address[31:5] == BASE_ADDR[31:5]);
  assign wr_sel = write_address[4:2];

  // Merge an old register value with the enabled byte lanes of the write data
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [3:0]  lanes,
                                              input logic [31:0] new_val);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (lanes[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

  // Byte-lane enables and lane-replicated write data from access size and address
  always_comb begin
    be    = 4'b0000;
    wdata = write_data;
    if (funct3[1]) begin
      be    = 4'b1111;
      wdata = write_data;
    end else if (funct3[0]) begin
      be    = write_address[1] ? 4'b1100 : 4'b0011;
      wdata = {2{write_data[15:0]}};
    end else begin
      be    = 4'b0001 << write_address[1:0];
      wdata = {4{write_data[7:0]}};
    end
  end

  assign us_tick     = (us_pre == 32'(US_DIV - 1));
  assign ms_tick     = (ms_pre == 32'(MS_DIV - 1));
  assign millis_next = millis + 32'd1;
  assign match       = ms_tick && (millis_next == cmp);

  // Microsecond and millisecond prescalers with their free-running counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      us_pre <= '0;
      micros <= '0;
      ms_pre <= '0;
      millis <= '0;
    end else begin
      if (us_tick) begin
        us_pre <= '0;
        micros <= micros + 32'd1;
      end else begin
        us_pre <= us_pre + 32'd1;
      end
      if (ms_tick) begin
        ms_pre <= '0;
        millis <= millis_next;
      end else begin
        ms_pre <= ms_pre + 32'd1;
      end
    end
  end

  // Compare timer registers; a software CMP write overrides the auto-reload
  // and a new match overrides a same-cycle clear of PENDING
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp     <= '0;
      period  <= '0;
      ctrl    <= '0;
      pending <= 1'b0;
    end else begin
      if (wr_hit && wr_sel == REG_CMP) begin
        cmp <= merge_lanes(cmp, be, wdata);
      end else if (match && ctrl[1]) begin
        cmp <= cmp + period;
      end
      if (wr_hit && wr_sel == REG_PERIOD) begin
        period <= merge_lanes(period, be, wdata);
      end
      if (wr_hit && wr_sel == REG_CTRL && be[0]) begin
        ctrl <= wdata[1:0];
      end
      if (match) begin
        pending <= 1'b1;
      end else if (wr_hit && wr_sel == REG_STATUS && be[0] && wdata[0]) begin
        pending <= 1'b0;
      end
    end
  end

  // Shadow duty registers, one byte per existing channel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_PWM; k++) duty[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_PWM; k++) begin
        if (wr_hit && wr_sel == 3'(k / 4) && be[k % 4]) begin
          duty[k] <= wdata[8*(k % 4) +: 8];
        end
      end
    end
  end

  assign pwm_step    = (div_cnt == 32'(PWM_DIV - 1));
  assign period_load = pwm_step && (pwm_cnt == 8'hFF);
  assign cnt_next    = pwm_step ? pwm_cnt + 8'd1 : pwm_cnt;

  // Next active duties and comparator results, so pwm_out can be a clean flop
  always_comb begin
    pwm_next = '0;
    for (int k = 0; k < NUM_PWM; k++) begin
      active_next[k] = period_load ? duty[k] : active_duty[k];
      pwm_next[k]    = (cnt_next < active_next[k]);
    end
  end

  // PWM divider, period counter, duty reload at wrap and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
      pwm_out <= '0;
      for (int k = 0; k < NUM_PWM; k++) active_duty[k] <= '0;
    end else begin
      div_cnt <= pwm_step ? '0 : div_cnt + 32'd1;
      pwm_cnt <= cnt_next;
      pwm_out <= pwm_next;
      for (int k = 0; k < NUM_PWM; k++) active_duty[k] <= active_next[k];
    end
  end

  // Pack the shadow duties into register words, absent channels read 0
  always_comb begin
    duty_all = '0;
    for (int k = 0; k < NUM_PWM; k++) duty_all[8*k +: 8] = duty[k];
  end

  assign rd_in_window = (read_address[31:5] == BASE_ADDR[31:5]);

  // Read multiplexer over the eight register offsets
  always_comb begin
    rd_value = '0;
    case (read_address[4:2])
      REG_DUTY_LO: rd_value = duty_all[31:0];
      REG_DUTY_HI: rd_value = duty_all[63:32];
      REG_MILLIS:  rd_value = millis;
      REG_MICROS:  rd_value = micros;
      REG_CMP:     rd_value = cmp;
      REG_CTRL:    rd_value = {30'b0, ctrl};
      REG_STATUS:  rd_value = {31'b0, pending};
      REG_PERIOD:  rd_value = period;
      default:     rd_value = '0;
    endcase
  end

  // Registered read port, zero outside the window
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_data <= '0;
      read_hit  <= 1'b0;
    end else begin
      read_data <= rd_in_window ? rd_value : 32'd0;
      read_hit  <= rd_in_window;
    end
  end

  assign irq = pending & ctrl[0];

endmodule
